odu_frame_align_check: RTL

Per-channel ODU framing checker that sits on the receive side of the channelised ODU word stream (valid / 384-bit data / fs / rs / mfas / chid) produced by the ODU generator. For each of up to 80 interleaved channels it tracks row/word position and MFAS sequence, acquires frame lock, and flags framing faults. The flagged faults include those created by the valid/fs/rs/mfas error-injection controls. Payload content is not checked here.

---
 rtl/odu_frame_align_check.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/odu_frame_align_check.sv
// Per-channel ODU frame alignment checker for the interleaved receive word stream.
// Tracks row/word/MFAS position per channel, acquires lock and flags framing faults.
//
// state   | meaning
// --------+-------------------------------------------------------------------
// HUNT    | waiting for a word carrying both fs and rs
// PRESYNC | one frame start seen; checking alignment up to the next frame start
// SYNC    | locked; any fs/rs/mfas mismatch is a counted, sticky error

module odu_frame_align_check #(
    parameter int NUM_CH    = 80,
    parameter int ROW_WORDS = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [383:0]      i_data,
    input  logic              i_fs,
    input  logic              i_rs,
    input  logic [7:0]        i_mfas,
    input  logic [6:0]        i_chid,
    input  logic              i_clr,
    output logic [NUM_CH-1:0] o_lock_chid,
    output logic [NUM_CH-1:0] o_error_chid,
    output logic              o_err_pulse,
    output logic [6:0]        o_err_id,
    output logic [15:0]       o_err_cnt
);

    localparam int             WW       = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam logic [WW-1:0]  W_LAST   = WW'(ROW_WORDS - 1);
    localparam logic [WW-1:0]  W_ONE    = WW'(1);
    localparam logic [7:0]     NUM_CH_L = 8'(NUM_CH);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } fsm_t;

    // Payload is not inspected; reduced only so the port is consumed.
    logic data_unused;
    assign data_unused = ^i_data;

    logic       valid_s1_q;
    logic       fs_s1_q;
    logic       rs_s1_q;
    logic [7:0] mfas_s1_q;
    logic [6:0] chid_s1_q;
    logic       clr_s1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1_q <= 1'b0;
            fs_s1_q    <= 1'b0;
            rs_s1_q    <= 1'b0;
            mfas_s1_q  <= 8'd0;
            chid_s1_q  <= 7'd0;
            clr_s1_q   <= 1'b0;
        end else begin
            valid_s1_q <= i_valid;
            fs_s1_q    <= i_fs;
            rs_s1_q    <= i_rs;
            mfas_s1_q  <= i_mfas;
            chid_s1_q  <= i_chid;
            clr_s1_q   <= i_clr;
        end
    end

    fsm_t          fsm_q [NUM_CH];
    logic [WW-1:0] w_q   [NUM_CH];
    logic [1:0]    r_q   [NUM_CH];
    logic [7:0]    em_q  [NUM_CH];

    fsm_t          cur_fsm;
    logic [WW-1:0] cur_w;
    logic [1:0]    cur_r;
    logic [7:0]    cur_em;
    logic          in_range;

    assign in_range = ({1'b0, chid_s1_q} < NUM_CH_L);
    assign cur_fsm  = fsm_q[chid_s1_q];
    assign cur_w    = w_q[chid_s1_q];
    assign cur_r    = r_q[chid_s1_q];
    assign cur_em   = em_q[chid_s1_q];

    fsm_t          fsm_d;
    logic [WW-1:0] w_d;
    logic [1:0]    r_d;
    logic [7:0]    em_d;
    logic          wr_en;
    logic          err_d;
    logic          fs_exp;
    logic          rs_exp;
    logic          match;
    logic [WW-1:0] w_adv;
    logic [1:0]    r_adv;
    logic [7:0]    em_adv;

    always_comb begin
        fsm_d  = cur_fsm;
        w_d    = cur_w;
        r_d    = cur_r;
        em_d   = cur_em;
        wr_en  = 1'b0;
        err_d  = 1'b0;
        fs_exp = (cur_r == 2'd0) && (cur_w == '0);
        rs_exp = (cur_w == '0);
        match  = (fs_s1_q == fs_exp) && (rs_s1_q == rs_exp) && (mfas_s1_q == cur_em);

        // Position one word ahead; MFAS rolls only when the last word of row 3 passes.
        if (cur_w == W_LAST) begin
            w_adv  = '0;
            r_adv  = cur_r + 2'd1;
            em_adv = (cur_r == 2'd3) ? cur_em + 8'd1 : cur_em;
        end else begin
            w_adv  = cur_w + W_ONE;
            r_adv  = cur_r;
            em_adv = cur_em;
        end

        if (valid_s1_q && in_range) begin
            wr_en = 1'b1;
            unique case (cur_fsm)
                HUNT: begin
                    if (fs_s1_q && rs_s1_q) begin
                        fsm_d = PRESYNC;
                        em_d  = mfas_s1_q;
                        w_d   = W_ONE;
                        r_d   = 2'd0;
                    end
                end
                PRESYNC: begin
                    if (!match) begin
                        fsm_d = HUNT;
                    end else begin
                        if (fs_exp) begin
                            fsm_d = SYNC;
                        end
                        w_d  = w_adv;
                        r_d  = r_adv;
                        em_d = em_adv;
                    end
                end
                SYNC: begin
                    if (!match) begin
                        fsm_d = HUNT;
                        err_d = 1'b1;
                    end else begin
                        w_d  = w_adv;
                        r_d  = r_adv;
                        em_d = em_adv;
                    end
                end
                default: fsm_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fsm_q[i] <= HUNT;
                w_q[i]   <= '0;
                r_q[i]   <= 2'd0;
                em_q[i]  <= 8'd0;
            end
        end else if (wr_en) begin
            fsm_q[chid_s1_q] <= fsm_d;
            w_q[chid_s1_q]   <= w_d;
            r_q[chid_s1_q]   <= r_d;
            em_q[chid_s1_q]  <= em_d;
        end
    end

    logic       err_s2_q;
    logic [6:0] id_s2_q;
    logic       clr_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_s2_q <= 1'b0;
            id_s2_q  <= 7'd0;
            clr_s2_q <= 1'b0;
        end else begin
            err_s2_q <= err_d;
            id_s2_q  <= chid_s1_q;
            clr_s2_q <= clr_s1_q;
        end
    end

    logic [NUM_CH-1:0] lock_vec;
    logic [NUM_CH-1:0] lock_q;
    logic [NUM_CH-1:0] errv_q;
    logic [NUM_CH-1:0] errv_base;
    logic [NUM_CH-1:0] errv_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_base;
    logic [15:0]       cnt_d;
    logic              pulse_q;
    logic              pulse_d;
    logic [6:0]        id_q;
    logic [6:0]        id_d;

    always_comb begin
        lock_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lock_vec[i] = (fsm_q[i] == SYNC);
        end
    end

    // Clear is applied before a coinciding error so the new error survives.
    always_comb begin
        errv_base = clr_s2_q ? '0 : errv_q;
        cnt_base  = clr_s2_q ? 16'd0 : cnt_q;
        errv_d    = errv_base;
        cnt_d     = cnt_base;
        pulse_d   = err_s2_q;
        id_d      = 7'd0;
        if (err_s2_q) begin
            errv_d = errv_base | ({{(NUM_CH-1){1'b0}}, 1'b1} << id_s2_q);
            id_d   = id_s2_q;
            if (cnt_base != 16'hFFFF) begin
                cnt_d = cnt_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= '0;
            errv_q  <= '0;
            cnt_q   <= 16'd0;
            pulse_q <= 1'b0;
            id_q    <= 7'd0;
        end else begin
            lock_q  <= lock_vec;
            errv_q  <= errv_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            id_q    <= id_d;
        end
    end

    assign o_lock_chid  = lock_q;
    assign o_error_chid = errv_q;
    assign o_err_pulse  = pulse_q;
    assign o_err_id     = id_q;
    assign o_err_cnt    = cnt_q;

endmodule
